// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in over a
// programmable window of clk cycles and offers the result in parallel and MSB-first serial form.
module ro_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              osc_in,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              shift,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              sout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [CNT_W-1:0]       edge_q, edge_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       sreg_q, sreg_d;
    logic                   rise;

    // Synchronizer and edge history run in every state so the window starts with clean history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            hist_q  <= 1'b0;
            gate_q  <= '0;
            edge_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q  <= sync_q[SYNC_STAGES-1];
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sreg_q  <= sreg_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        sreg_d  = sreg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    gate_d  = gate_len;
                    edge_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gate_q != '0) begin
                    gate_d = gate_q - GATE_ONE;
                    if (rise) begin
                        if (edge_q != '1) begin
                            edge_d = edge_q + CNT_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    count_d = edge_q;
                    sreg_d  = edge_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A restart takes precedence over a shift requested in the same cycle.
                if (start) begin
                    gate_d  = gate_len;
                    edge_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = S_MEASURE;
                end else if (shift) begin
                    sreg_d = {sreg_q[CNT_W-2:0], 1'b0};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == S_MEASURE);
    assign done     = (state_q == S_DONE);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign sout     = sreg_q[CNT_W-1];

endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Downstream measurement stage for the ring-oscillator clock path.
- Samples an asynchronous oscillator-derived signal, for example the divided ring clock, in the system clock domain.
- Counts its rising edges over a programmable gate window of clk cycles.
- Latches the result and presents it in parallel and as an MSB-first serial stream, advanced by a shift strobe, with a done flag for pin-level readout.

Parameters:
- CNT_W, 16: width of the edge counter and the result.
- GATE_W, 16: width of the gate-length input and the gate counter.
- SYNC_STAGES, 2: flip-flop depth of the osc_in synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  reset, asynchronous and active-low.
- osc_in  input  1  asynchronous oscillator-derived signal; its frequency must be at most clk/4 for exact counts.
- start  input  1  synchronous; begins a measurement when the block is in IDLE or DONE.
- abort  input  1  synchronous; cancels a measurement in MEASURE.
- gate_len  input  GATE_W  window length in clk cycles; sampled on start.
- shift  input  1  synchronous, one bit per high cycle; advances the serial output in DONE.
- busy  output  1  high while in MEASURE.
- done  output  1  high while in DONE.
- count  output  CNT_W  latched result of the last completed measurement.
- overflow  output  1  edge counter saturated during the last measurement.
- sout  output  1  serial data; always equals the MSB of the shift register.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, count=0, overflow=0, sout=0.
  - Shift register, gate counter, edge counter and all synchronizer flops are cleared.
  - Reset takes effect mid-measurement with no completion.
- Synchronizer and edge detector:
  - osc_in passes through SYNC_STAGES flops, then one history flop. These run in every state.
  - rise = last sync stage & ~history flop; at most one rise per cycle.
- IDLE:
  - start=1: gate_cnt<=gate_len, edge_cnt<=0, overflow<=0, state<=MEASURE.
- MEASURE (busy=1):
  - abort=1 has priority: state<=IDLE. count, overflow and the shift register keep their prior values; done stays 0.
  - Else, if gate_cnt!=0: gate_cnt<=gate_cnt-1. If rise: edge_cnt<=edge_cnt+1 when not all-ones; otherwise edge_cnt holds and overflow<=1.
  - Else (gate_cnt==0): count<=edge_cnt, shift register<=edge_cnt, state<=DONE.
  - start is ignored in this state.
- Window and latency:
  - Exactly gate_len cycles sample rise, starting the cycle after start.
  - done rises gate_len+2 cycles after the start cycle.
  - gate_len=0: no cycles are sampled; result is 0 and done rises 2 cycles after start.
- DONE (done=1):
  - shift=1: shift register shifts left by one with 0 fill.
  - After CNT_W shifts sout=0 and stays 0 until reload.
  - start=1 restarts exactly as from IDLE. done drops next cycle; count and the shift register keep their values until the new measurement completes.
  - start and shift in the same cycle: start wins and no shift occurs.
  - abort is ignored in this state.
- Arithmetic:
  - All counters are unsigned.
  - edge_cnt saturates at 2^CNT_W-1 and never wraps.
  - gate_cnt decrements only when nonzero.

Test Plan:
1. Square wave on osc_in, period 10 clk, gate_len=100, start pulse → busy for 101 cycles, then done=1, count=10, overflow=0.
2. With the result 0x00A5 (CNT_W=16) in DONE, 16 single-cycle shift pulses → sout sequence 0,0,0,0,0,0,0,0,1,0,1,0,0,1,0,1 (sampled before each shift); after the 16th shift sout=0 and remains 0.
3. CNT_W=4, osc_in period 4, gate_len=80 → count=15, overflow=1; a following run with gate_len=8 → count=2, overflow=0.
4. gate_len=0, start → done=1 two cycles after start, count=0; then gate_len=40 with osc period 8, start asserted in DONE together with shift → done drops next cycle, no shift, new count=5.
5. During MEASURE: abort at cycle 30 → IDLE, done=0, count keeps its previous value. Separately, rst_n pulsed low mid-MEASURE → all outputs 0 immediately, and the next start works normally.
6. osc_in held constant at 1 across start, gate_len=50 → count=0; a single 0→1 transition mid-window → count=1.
